// File: rtl/rram_ctrl_pkg.sv
// rtl/rram_ctrl_pkg.sv - shared types and default sizes for the RRAM write-verify controller
package rram_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 6;
    localparam int MAX_RETRY_DEF  = 3;
    localparam int FAIL_CNT_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RCAP,
        ST_WRITE,
        ST_VERIFY,
        ST_VCAP,
        ST_RESP
    } state_e;

endpackage

// File: rtl/rram_wv_ctrl.sv
// rtl/rram_wv_ctrl.sv - request-side RRAM controller with write, read-back verify and bounded retry
module rram_wv_ctrl
    import rram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MAX_RETRY  = MAX_RETRY_DEF,
    parameter int RW         = $clog2(MAX_RETRY + 1)
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_fail,
    output logic [RW-1:0]         rsp_retries,
    output logic [FAIL_CNT_W-1:0] fail_cnt,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_e                state_q, state_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_fail_q, rsp_fail_d;
    logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    // Macro pins are computed from the next state so they are valid for the access edge.
    always_comb begin
        state_d     = state_q;
        csb0_d      = 1'b1;
        web0_d      = 1'b1;
        addr0_d     = addr0_q;
        din0_d      = din0_q;
        wdata_d     = wdata_q;
        retry_d     = retry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fail_d  = rsp_fail_q;
        fail_cnt_d  = fail_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr0_d    = req_addr;
                    wdata_d    = req_wdata;
                    retry_d    = '0;
                    rsp_fail_d = 1'b0;
                    csb0_d     = 1'b0;
                    if (req_write) begin
                        state_d = ST_WRITE;
                        web0_d  = 1'b0;
                        din0_d  = req_wdata;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: state_d = ST_RCAP;
            ST_RCAP: begin
                rsp_rdata_d = dout0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_WRITE: begin
                csb0_d  = 1'b0;
                state_d = ST_VERIFY;
            end
            ST_VERIFY: state_d = ST_VCAP;
            ST_VCAP: begin
                rsp_rdata_d = dout0;
                if (dout0 == wdata_q) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (retry_q != RETRY_LIMIT) begin
                    retry_d = retry_q + 1'b1;
                    csb0_d  = 1'b0;
                    web0_d  = 1'b0;
                    state_d = ST_WRITE;
                end else begin
                    rsp_fail_d  = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (fail_cnt_q != '1) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rst0_n) begin
            state_q     <= ST_IDLE;
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            addr0_q     <= '0;
            din0_q      <= '0;
            wdata_q     <= '0;
            retry_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fail_q  <= 1'b0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            csb0_q      <= csb0_d;
            web0_q      <= web0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            wdata_q     <= wdata_d;
            retry_q     <= retry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fail_q  <= rsp_fail_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE) && rst0_n;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_fail    = rsp_fail_q;
    assign rsp_retries = retry_q;
    assign fail_cnt    = fail_cnt_q;
    assign csb0        = csb0_q;
    assign web0        = web0_q;
    assign addr0       = addr0_q;
    assign din0        = din0_q;

endmodule

// File: tb/tb_rram_wv_ctrl.sv
// tb/tb_rram_wv_ctrl.sv - directed self-checking bench for rram_wv_ctrl with a behavioural 64x16 macro
module tb_rram_wv_ctrl;

    logic        clk0 = 1'b0;
    logic        rst0_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_fail;
    logic [1:0]  rsp_retries;
    logic [7:0]  fail_cnt;
    logic        csb0, web0;
    logic [5:0]  addr0;
    logic [15:0] din0;
    logic [15:0] dout0;

    logic [15:0] mem [64];
    logic [15:0] mac_q = '0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic        stuck_b0 = 1'b0;
    int          flip_idx = -1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk0 = ~clk0;

    rram_wv_ctrl dut (
        .clk0(clk0), .rst0_n(rst0_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_fail(rsp_fail), .rsp_retries(rsp_retries), .fail_cnt(fail_cnt),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    // Macro model: synchronous access, read data appears 3 time units after the edge.
    initial begin
        logic [15:0] rd;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[5] = 16'hA5A5;
        forever begin
            @(posedge clk0);
            if (!csb0) begin
                if (!web0) begin
                    mem[addr0] = din0;
                    wr_cnt++;
                end else begin
                    rd = mem[addr0];
                    if (rd_cnt == flip_idx) rd = rd ^ 16'hFFFF;
                    if (stuck_b0) rd = rd | 16'h0001;
                    rd_cnt++;
                    mac_q <= #3 rd;
                end
            end
        end
    end
    assign dout0 = mac_q;

    task automatic do_req(input logic w, input logic [5:0] a, input logic [15:0] d, output int lat);
        @(negedge clk0);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk0);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk0);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk0);
        rsp_ready = 1'b1;
        @(posedge clk0);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst0_n = 1'b0;
        repeat (3) @(posedge clk0);
        #1;
        n_total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %0b want 0", req_ready); else n_pass++;
        n_total++; if (csb0 !== 1'b1 || web0 !== 1'b1) $display("FAIL reset_csb_web got %0b%0b want 11", csb0, web0); else n_pass++;
        n_total++; if (addr0 !== 6'd0 || din0 !== 16'h0) $display("FAIL reset_addr_din got %h/%h want 0/0", addr0, din0); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0 || fail_cnt !== 8'd0) $display("FAIL reset_rsp got v=%0b fc=%0d want 0/0", rsp_valid, fail_cnt); else n_pass++;
        @(negedge clk0);
        rst0_n = 1'b1;
        #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL post_reset_ready got %0b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_read();
        int lat;
        do_req(1'b0, 6'd5, 16'h0, lat);
        n_total++; if (lat !== 2) $display("FAIL read_latency got %0d want 2", lat); else n_pass++;
        n_total++; if (rsp_rdata !== 16'hA5A5) $display("FAIL read_data got %h want a5a5", rsp_rdata); else n_pass++;
        n_total++; if (rsp_fail !== 1'b0 || rsp_retries !== 2'd0) $display("FAIL read_flags got f=%0b r=%0d want 0/0", rsp_fail, rsp_retries); else n_pass++;
        consume();
    endtask

    task automatic test_write_read();
        int lat;
        int w0;
        w0 = wr_cnt;
        do_req(1'b1, 6'd63, 16'h1234, lat);
        n_total++; if (lat !== 3) $display("FAIL write_latency got %0d want 3", lat); else n_pass++;
        n_total++; if (rsp_fail !== 1'b0 || rsp_retries !== 2'd0) $display("FAIL write_flags got f=%0b r=%0d want 0/0", rsp_fail, rsp_retries); else n_pass++;
        n_total++; if (wr_cnt - w0 !== 1) $display("FAIL write_strobes got %0d want 1", wr_cnt - w0); else n_pass++;
        consume();
        do_req(1'b0, 6'd63, 16'h0, lat);
        n_total++; if (rsp_rdata !== 16'h1234) $display("FAIL readback63 got %h want 1234", rsp_rdata); else n_pass++;
        consume();
    endtask

    task automatic test_stuck_fail();
        int lat;
        int w0;
        w0 = wr_cnt;
        stuck_b0 = 1'b1;
        do_req(1'b1, 6'd2, 16'h0000, lat);
        stuck_b0 = 1'b0;
        n_total++; if (wr_cnt - w0 !== 4) $display("FAIL stuck_strobes got %0d want 4", wr_cnt - w0); else n_pass++;
        n_total++; if (lat !== 12) $display("FAIL stuck_latency got %0d want 12", lat); else n_pass++;
        n_total++; if (rsp_fail !== 1'b1 || rsp_retries !== 2'd3) $display("FAIL stuck_flags got f=%0b r=%0d want 1/3", rsp_fail, rsp_retries); else n_pass++;
        n_total++; if (rsp_rdata !== 16'h0001) $display("FAIL stuck_rdata got %h want 0001", rsp_rdata); else n_pass++;
        n_total++; if (fail_cnt !== 8'd1) $display("FAIL stuck_fail_cnt got %0d want 1", fail_cnt); else n_pass++;
        consume();
    endtask

    task automatic test_retry_once();
        int lat;
        flip_idx = rd_cnt;
        do_req(1'b1, 6'd10, 16'h5A5A, lat);
        flip_idx = -1;
        n_total++; if (lat !== 6) $display("FAIL retry1_latency got %0d want 6", lat); else n_pass++;
        n_total++; if (rsp_fail !== 1'b0 || rsp_retries !== 2'd1) $display("FAIL retry1_flags got f=%0b r=%0d want 0/1", rsp_fail, rsp_retries); else n_pass++;
        n_total++; if (rsp_rdata !== 16'h5A5A || fail_cnt !== 8'd1) $display("FAIL retry1_data got %h fc=%0d want 5a5a/1", rsp_rdata, fail_cnt); else n_pass++;
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        do_req(1'b0, 6'd63, 16'h0, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk0);
            #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234 || req_ready !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL hold_stable got %0d bad cycles want 0", bad); else n_pass++;
        consume();
        n_total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL hold_release got rdy=%0b v=%0b want 1/0", req_ready, rsp_valid); else n_pass++;
    endtask

    task automatic test_reset_in_verify();
        int lat;
        @(negedge clk0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 6'd20;
        req_wdata = 16'hBEEF;
        @(posedge clk0);
        #1;
        req_valid = 1'b0;
        @(posedge clk0);
        #1;
        rst0_n = 1'b0;
        @(posedge clk0);
        #1;
        n_total++; if (csb0 !== 1'b1 || web0 !== 1'b1 || addr0 !== 6'd0 || din0 !== 16'h0) $display("FAIL rstv_pins got c=%0b w=%0b a=%h d=%h want 1/1/0/0", csb0, web0, addr0, din0); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || fail_cnt !== 8'd0 || req_ready !== 1'b0) $display("FAIL rstv_rsp got v=%0b d=%h fc=%0d rdy=%0b want 0/0/0/0", rsp_valid, rsp_rdata, fail_cnt, req_ready); else n_pass++;
        @(negedge clk0);
        rst0_n = 1'b1;
        do_req(1'b0, 6'd5, 16'h0, lat);
        n_total++; if (lat !== 2 || rsp_rdata !== 16'hA5A5) $display("FAIL rstv_read got lat=%0d d=%h want 2/a5a5", lat, rsp_rdata); else n_pass++;
        consume();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_stuck_fail();
        test_retry_once();
        test_backpressure();
        test_reset_in_verify();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
